// File: rtl/fetch_prefetch_stage.sv
// Fetch stage: owns the PC, issues one ROM read per cycle and buffers
// {pc, instr} pairs in a prefetch FIFO drained by decode.
module fetch_prefetch_stage #(
    parameter int          ADDR_W      = 16,
    parameter int          INSTR_W     = 20,
    parameter int          PC_STEP     = 1,
    parameter int          QUEUE_DEPTH = 4,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               imem_req,
    output logic [ADDR_W-1:0]                  imem_addr,
    input  logic [INSTR_W-1:0]                 imem_rdata,
    input  logic                               redirect_valid,
    input  logic [ADDR_W-1:0]                  redirect_pc,
    input  logic                               dec_ready,
    output logic                               dec_valid,
    output logic [INSTR_W-1:0]                 dec_instr,
    output logic [ADDR_W-1:0]                  dec_pc,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [CW:0]       DEPTH  = (CW+1)'(QUEUE_DEPTH);

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflight_pc;
    logic [ADDR_W-1:0]  r_mem_pc    [QUEUE_DEPTH];
    logic [INSTR_W-1:0] r_mem_instr [QUEUE_DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic [CW:0]        w_occ;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_addr;

    // A redirect discards queue and in-flight read, so the target may
    // always be issued in the redirect cycle itself.
    always_comb begin
        w_occ   = redirect_valid ? '0
                : ({1'b0, r_count} + (CW+1)'(r_inflight));
        w_issue = !reset && (w_occ < DEPTH);
        w_addr  = redirect_valid ? redirect_pc : r_fetch_pc;
        w_push  = r_inflight && !redirect_valid;
        w_pop   = (r_count != '0) && dec_ready && !redirect_valid;
    end

    assign imem_req    = w_issue;
    assign imem_addr   = w_addr;
    assign dec_valid   = (r_count != '0);
    assign dec_pc      = r_mem_pc[r_rd_ptr];
    assign dec_instr   = r_mem_instr[r_rd_ptr];
    assign queue_count = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= PC_RST;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (w_issue) begin
            r_fetch_pc    <= w_addr + STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= w_addr;
        end else begin
            r_fetch_pc    <= w_addr;
            r_inflight    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: queue-based reference model plus
// directed scenarios and a randomized stream.
module tb_fetch_prefetch_stage;

    localparam int AW = 16;
    localparam int IW = 20;
    localparam int D  = 4;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          dec_ready;
    logic          dec_valid;
    logic [IW-1:0] dec_instr;
    logic [AW-1:0] dec_pc;
    logic [CW-1:0] queue_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_prefetch_stage #(
        .ADDR_W(AW), .INSTR_W(IW), .PC_STEP(1),
        .QUEUE_DEPTH(D), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_ready(dec_ready), .dec_valid(dec_valid),
        .dec_instr(dec_instr), .dec_pc(dec_pc),
        .queue_count(queue_count)
    );

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
        return IW'(a) + IW'(20'h00100);
    endfunction

    initial imem_rdata = '0;
    always @(posedge clk) if (imem_req) imem_rdata <= rom(imem_addr);

    // Reference model: fetch pointer, one outstanding read, entry queue
    typedef struct { logic [AW-1:0] pc; logic [IW-1:0] ins; } ent_t;
    ent_t          m_q[$];
    logic [AW-1:0] m_fpc;
    logic [AW-1:0] m_ipc;
    bit            m_infl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fpc  = '0;
        m_ipc  = '0;
        m_infl = 0;
    endtask

    function automatic int m_occ();
        return redirect_valid ? 0 : m_q.size() + int'(m_infl);
    endfunction

    function automatic logic [AW-1:0] m_addr();
        return redirect_valid ? redirect_pc : m_fpc;
    endfunction

    task automatic model_compare();
        chk("imem_req", 32'(imem_req), 32'(m_occ() < D));
        chk("imem_addr", 32'(imem_addr), 32'(m_addr()));
        chk("queue_count", 32'(queue_count), 32'(m_q.size()));
        chk("dec_valid", 32'(dec_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("dec_pc", 32'(dec_pc), 32'(m_q[0].pc));
            chk("dec_instr", 32'(dec_instr), 32'(m_q[0].ins));
        end
    endtask

    task automatic model_step();
        bit            req;
        bit            push;
        bit            pop;
        logic [AW-1:0] addr;
        if (reset) begin
            model_reset();
            return;
        end
        req  = m_occ() < D;
        addr = m_addr();
        push = m_infl && !redirect_valid;
        pop  = (m_q.size() != 0) && dec_ready && !redirect_valid;
        if (redirect_valid) m_q.delete();
        else begin
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back('{m_ipc, rom(m_ipc)});
        end
        if (m_q.size() > D) begin
            n_cmp++;
            n_bad++;
            $display("FAIL model_overflow: size %0d limit %0d", m_q.size(), D);
        end
        if (req) begin
            m_fpc  = addr + AW'(1);
            m_infl = 1;
            m_ipc  = addr;
        end else begin
            m_fpc  = addr;
            m_infl = 0;
        end
    endtask

    // Called at a negedge: apply inputs, then compare against the model
    task automatic drive(input bit rv, input logic [AW-1:0] rpc, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
        model_compare();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        #1;
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_queue_count", 32'(queue_count), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dec_pc", 32'(dec_pc), 32'd0);
        chk("rst_dec_instr", 32'(dec_instr), 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] wrap_seq [4];
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        dec_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: streaming after reset
        for (int c = 0; c < 10; c++) begin
            drive(0, '0, 1);
            if (c == 0) begin
                chk("t1_first_addr", 32'(imem_addr), 32'h0);
                chk("t1_c0_valid", 32'(dec_valid), 32'd0);
            end
            if (c == 1) chk("t1_c1_valid", 32'(dec_valid), 32'd0);
            if (c >= 2) begin
                chk("t1_valid", 32'(dec_valid), 32'd1);
                chk("t1_pc", 32'(dec_pc), 32'(c - 2));
                chk("t1_instr", 32'(dec_instr), 32'(20'h00100 + c - 2));
            end
            tick();
        end

        // 2: decode stalled, queue fills, then drains in order
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, '0, 0);
            tick();
        end
        drive(0, '0, 0);
        chk("t2_count_full", 32'(queue_count), 32'd4);
        chk("t2_req_low", 32'(imem_req), 32'd0);
        chk("t2_fetch_pc", 32'(imem_addr), 32'd4);
        exp_pc = '0;
        for (int c = 0; c < 12; c++) begin
            drive(0, '0, 1);
            if (dec_valid) begin
                chk("t2_order", 32'(dec_pc), 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end
        chk("t2_drained", 32'(exp_pc >= 10), 32'd1);

        // 3: redirect with three queued entries
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, '0, 0);
            tick();
        end
        drive(1, 16'h0040, 0);
        chk("t3_count_pre", 32'(queue_count), 32'd3);
        chk("t3_addr", 32'(imem_addr), 32'h40);
        chk("t3_req", 32'(imem_req), 32'd1);
        tick();
        drive(0, '0, 1);
        chk("t3_count_flushed", 32'(queue_count), 32'd0);
        chk("t3_valid_gap", 32'(dec_valid), 32'd0);
        tick();
        drive(0, '0, 1);
        chk("t3_pc0", 32'(dec_pc), 32'h40);
        tick();
        drive(0, '0, 1);
        chk("t3_pc1", 32'(dec_pc), 32'h41);
        tick();

        // 4: redirect while popping and with a response arriving
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(0, '0, 1);
            tick();
        end
        drive(1, 16'h0200, 1);
        chk("t4_head_shown", 32'(dec_valid), 32'd1);
        tick();
        chk("t4_count_flushed", 32'(queue_count), 32'd0);
        exp_pc = 16'h0200;
        for (int c = 0; c < 8; c++) begin
            drive(0, '0, 1);
            if (dec_valid) begin
                chk("t4_no_stale", 32'(dec_pc), 32'(exp_pc));
                exp_pc++;
            end
            tick();
        end

        // 5: PC wraps through 0xFFFF
        do_reset();
        wrap_seq[0] = 16'hFFFE;
        wrap_seq[1] = 16'hFFFF;
        wrap_seq[2] = 16'h0000;
        wrap_seq[3] = 16'h0001;
        for (int c = 0; c < 3; c++) begin
            drive(0, '0, 1);
            tick();
        end
        drive(1, 16'hFFFE, 1);
        tick();
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive(0, '0, 1);
            if (dec_valid && k < 4) begin
                chk("t5_wrap_pc", 32'(dec_pc), 32'(wrap_seq[k]));
                k++;
            end
            tick();
        end
        chk("t5_wrap_seen", 32'(k), 32'd4);

        // 6: reset mid-stream with three entries queued
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, '0, 0);
            tick();
        end
        drive(0, '0, 0);
        chk("t6_count_pre", 32'(queue_count), 32'd3);
        do_reset();
        drive(0, '0, 1);
        chk("t6_restart_addr", 32'(imem_addr), 32'h0);
        tick();
        drive(0, '0, 1);
        tick();
        drive(0, '0, 1);
        chk("t6_restart_pc", 32'(dec_pc), 32'h0);
        tick();

        // Randomized stream
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 19) == 0, AW'($urandom),
                      $urandom_range(0, 9) < 7);
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
